led_spi_frame_rx: RTL and testbench
===================================

Name: led_spi_frame_rx

Overview:
- SPI-slave command receiver upstream of the LED matrix pixel store (64 pixels, 8-bit R/G/B).
- Synchronises raw sclk/mosi/cs into the system clock domain and decodes 32-bit command words.
- Emits single-cycle pixel write strobes (address plus 24-bit RGB); the pixel store writes red/green/blue arrays directly from them.
- Supports single-pixel write, auto-increment burst and whole-matrix fill.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the sclk/mosi/cs synchronisers (minimum 2).
- NUM_PIX, 64, pixel count; fill length and burst wrap point (address width fixed at 6).

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset
- sclk  in  1  SPI clock, asynchronous, mode 0, MSB first
- mosi  in  1  SPI data, asynchronous
- cs  in  1  chip select, active low, asynchronous
- pix_we  out  1  pixel write strobe, one clk wide
- pix_addr  out  6  pixel index, row*8+col
- pix_rgb  out  24  {R[23:16], G[15:8], B[7:0]}
- busy  out  1  high while FILL runs
- frame_done  out  1  one-clk pulse on cs rise after at least one accepted header
- err  out  1  one-clk pulse on protocol error

Behaviour:
- Clock and reset: one clock clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-operation aborts any word or fill with no further strobes.
- Synchronisers:
  - sclk, mosi and cs each pass through SYNC_STAGES flops.
  - A rise is detected on the synced sclk versus its previous value; mosi is sampled from the synced value in that cycle.
  - sclk high and low phases must each be at least SYNC_STAGES+2 clk cycles.
- Header word: 32 bits. [31:30] cmd, [29:24] addr, [23:0] rgb.
- States:
  - IDLE: bit count cleared; synced cs low -> HDR.
  - HDR: shift bits in; on the 32nd bit decode cmd:
    - 00 -> SINGLE.
    - 01 -> BURST: write header pixel, next addr = addr+1.
    - 10 -> FILL.
    - 11 -> err pulse, go to WAIT_CS.
  - SINGLE: header pixel written; go to WAIT_CS. Further bits are ignored.
  - BURST: shift 24-bit groups. Each complete group writes pix_addr = current addr, then increments; 63 wraps to 0.
  - FILL: pix_we high for NUM_PIX consecutive clk cycles, addr 0..63, rgb = header rgb, busy high throughout. Then -> WAIT_CS, or IDLE if cs is already high.
  - WAIT_CS: ignore sclk; synced cs high -> IDLE.
- Write latency: pix_we, pix_addr and pix_rgb are registered. They appear in the clk cycle after the cycle in which the final bit's synced sclk rise is detected. pix_addr and pix_rgb hold their last values when pix_we is low.
- Boundary conditions:
  - cs rise in HDR or BURST with a nonzero bit count in the current word/group: discard partial bits, no write, err pulse, -> IDLE.
  - cs rise with zero partial bits: no err.
  - cs rise during FILL: fill still completes all NUM_PIX strobes. frame_done pulses the cycle after the last fill strobe.
  - SPI edges during FILL are ignored. Bits arriving during FILL are lost, not queued.
  - frame_done and err are never both high. If both would fire, err wins and frame_done is suppressed.
  - A new frame needs cs high for at least SYNC_STAGES+1 clk cycles.

Test Plan:
- Single write: cs low, word 0x05_FF8000 (cmd 00, addr 5), cs high -> exactly one pix_we, addr 5, rgb FF8000; frame_done one pulse about SYNC_STAGES+1 clk after the cs rise; err never asserted.
- Burst: header 0x7E_112233 (cmd 01, addr 62), then groups 0x445566 and 0x778899 -> three strobes: addr 62/112233, 63/445566, 0/778899 (wrap).
- Fill: header 0x80_0000FF, cs raised 10 clk after the last bit -> 64 consecutive strobes, addr 0..63, rgb 0000FF; busy high exactly 64 cycles; frame_done after the last strobe.
- Errors:
  - cmd 11 header -> err pulse, no strobe.
  - Separately, cs raised after 17 bits of a header -> err pulse, no strobe, returns to IDLE.
- Reset mid-fill: assert rst at fill strobe 20 -> pix_we low the next cycle, busy 0, no further strobes; a subsequent single write works normally.
- Back-to-back frames: two single writes separated by cs high for 4 clk -> two strobes and two frame_done pulses, both with correct data.

Source files
------------

// File: rtl/led_spi_frame_rx.sv
// rtl/led_spi_frame_rx.sv - SPI-slave command receiver that decodes 32-bit words into pixel write strobes
// Handles single-pixel write, auto-increment burst and whole-matrix fill; the raw SPI pins are synchronised into clk.
module led_spi_frame_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_PIX     = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sclk,
   input  logic        mosi,
   input  logic        cs,
   output logic        pix_we,
   output logic [5:0]  pix_addr,
   output logic [23:0] pix_rgb,
   output logic        busy,
   output logic        frame_done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_SINGLE, S_BURST, S_FILL, S_WAIT_CS
   } state_t;

   localparam logic [5:0] LAST_PIX = 6'(NUM_PIX - 1);

   function automatic logic [5:0] next_addr(input logic [5:0] a);
      return (a == LAST_PIX) ? 6'd0 : a + 6'd1;
   endfunction

   logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
   logic                   sclk_prev;
   logic                   sclk_s, mosi_s, cs_s, sclk_rise;

   state_t      state, state_n;
   logic [4:0]  bit_cnt, bit_cnt_n;
   logic [30:0] shreg, shreg_n;
   logic [31:0] bit_in;
   logic [5:0]  cur_addr, addr_n;
   logic [23:0] hdr_rgb, rgb_n;
   logic        hdr_ok, hdr_ok_n;
   logic        done_pend, done_pend_n;
   logic        we_n, busy_n, done_n, err_n;
   logic [5:0]  paddr_n;
   logic [23:0] prgb_n;

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev;
   assign bit_in    = {shreg, mosi_s};

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync  <= '0;
         mosi_sync  <= '0;
         cs_sync    <= '1;
         sclk_prev  <= 1'b0;
         state      <= S_IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         cur_addr   <= '0;
         hdr_rgb    <= '0;
         hdr_ok     <= 1'b0;
         done_pend  <= 1'b0;
         pix_we     <= 1'b0;
         pix_addr   <= '0;
         pix_rgb    <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         err        <= 1'b0;
      end else begin
         sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         cs_sync    <= {cs_sync[SYNC_STAGES-2:0], cs};
         sclk_prev  <= sclk_s;
         state      <= state_n;
         bit_cnt    <= bit_cnt_n;
         shreg      <= shreg_n;
         cur_addr   <= addr_n;
         hdr_rgb    <= rgb_n;
         hdr_ok     <= hdr_ok_n;
         done_pend  <= done_pend_n;
         pix_we     <= we_n;
         pix_addr   <= paddr_n;
         pix_rgb    <= prgb_n;
         busy       <= busy_n;
         frame_done <= done_n;
         err        <= err_n;
      end
   end

   always_comb begin
      state_n     = state;
      bit_cnt_n   = bit_cnt;
      shreg_n     = shreg;
      addr_n      = cur_addr;
      rgb_n       = hdr_rgb;
      hdr_ok_n    = hdr_ok;
      done_pend_n = 1'b0;
      we_n        = 1'b0;
      paddr_n     = pix_addr;
      prgb_n      = pix_rgb;
      busy_n      = 1'b0;
      done_n      = done_pend;
      err_n       = 1'b0;

      case (state)
         S_IDLE: begin
            bit_cnt_n = '0;
            hdr_ok_n  = 1'b0;
            if (!cs_s) state_n = S_HDR;
         end

         S_HDR: begin
            if (cs_s) begin
               err_n   = (bit_cnt != 5'd0);
               state_n = S_IDLE;
            end else if (sclk_rise) begin
               shreg_n   = bit_in[30:0];
               bit_cnt_n = bit_cnt + 5'd1;
               if (bit_cnt == 5'd31) begin
                  bit_cnt_n = '0;
                  rgb_n     = bit_in[23:0];
                  prgb_n    = bit_in[23:0];
                  case (bit_in[31:30])
                     2'b00: begin
                        we_n     = 1'b1;
                        paddr_n  = bit_in[29:24];
                        hdr_ok_n = 1'b1;
                        state_n  = S_SINGLE;
                     end
                     2'b01: begin
                        we_n     = 1'b1;
                        paddr_n  = bit_in[29:24];
                        addr_n   = next_addr(bit_in[29:24]);
                        hdr_ok_n = 1'b1;
                        state_n  = S_BURST;
                     end
                     2'b10: begin
                        // first fill strobe issues straight from the decode cycle
                        we_n     = 1'b1;
                        busy_n   = 1'b1;
                        paddr_n  = 6'd0;
                        addr_n   = next_addr(6'd0);
                        hdr_ok_n = 1'b1;
                        state_n  = S_FILL;
                     end
                     default: begin
                        prgb_n  = pix_rgb;
                        err_n   = 1'b1;
                        state_n = S_WAIT_CS;
                     end
                  endcase
               end
            end
         end

         S_SINGLE: begin
            if (cs_s) begin
               done_n  = hdr_ok;
               state_n = S_IDLE;
            end else begin
               state_n = S_WAIT_CS;
            end
         end

         S_BURST: begin
            if (cs_s) begin
               state_n = S_IDLE;
               if (bit_cnt != 5'd0) err_n = 1'b1;
               else                 done_n = hdr_ok;
            end else if (sclk_rise) begin
               shreg_n   = bit_in[30:0];
               bit_cnt_n = bit_cnt + 5'd1;
               if (bit_cnt == 5'd23) begin
                  bit_cnt_n = '0;
                  we_n      = 1'b1;
                  paddr_n   = cur_addr;
                  prgb_n    = bit_in[23:0];
                  addr_n    = next_addr(cur_addr);
               end
            end
         end

         S_FILL: begin
            we_n    = 1'b1;
            busy_n  = 1'b1;
            paddr_n = cur_addr;
            prgb_n  = hdr_rgb;
            if (cur_addr == LAST_PIX) begin
               addr_n = '0;
               // frame_done must trail the last strobe, so it is deferred one cycle
               if (cs_s) begin
                  done_pend_n = hdr_ok;
                  state_n     = S_IDLE;
               end else begin
                  state_n = S_WAIT_CS;
               end
            end else begin
               addr_n = next_addr(cur_addr);
            end
         end

         S_WAIT_CS: begin
            if (cs_s) begin
               done_n  = hdr_ok;
               state_n = S_IDLE;
            end
         end

         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_led_spi_frame_rx.sv
// tb/tb_led_spi_frame_rx.sv - directed bench for led_spi_frame_rx
module tb_led_spi_frame_rx;

   logic        clk = 1'b0;
   logic        rst, sclk, mosi, cs;
   logic        pix_we, busy, frame_done, err;
   logic [5:0]  pix_addr;
   logic [23:0] pix_rgb;

   int pass_cnt = 0;
   int check_cnt = 0;
   int cyc = 0;
   int last_rise, cs_rise;

   int          we_cyc_q[$];
   logic [5:0]  we_addr_q[$];
   logic [23:0] we_rgb_q[$];
   int          done_q[$];
   int          err_cnt, busy_cnt, both_cnt;

   led_spi_frame_rx #(.SYNC_STAGES(2), .NUM_PIX(64)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs(cs),
      .pix_we(pix_we), .pix_addr(pix_addr), .pix_rgb(pix_rgb),
      .busy(busy), .frame_done(frame_done), .err(err)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (pix_we) begin
         we_cyc_q.push_back(cyc);
         we_addr_q.push_back(pix_addr);
         we_rgb_q.push_back(pix_rgb);
      end
      if (frame_done) done_q.push_back(cyc);
      if (err) err_cnt++;
      if (busy) busy_cnt++;
      if (frame_done && err) both_cnt++;
   end

   task automatic clear_mon();
      @(posedge clk);
      we_cyc_q.delete();
      we_addr_q.delete();
      we_rgb_q.delete();
      done_q.delete();
      err_cnt = 0;
      busy_cnt = 0;
      both_cnt = 0;
      @(negedge clk);
   endtask

   task automatic spi_bit(input logic b);
      mosi = b;
      repeat (6) @(negedge clk);
      sclk = 1'b1;
      last_rise = cyc;
      repeat (6) @(negedge clk);
      sclk = 1'b0;
   endtask

   task automatic send_bits(input logic [31:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) spi_bit(w[i]);
   endtask

   task automatic cs_low();
      cs = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic cs_high(input int settle);
      repeat (6) @(negedge clk);
      cs = 1'b1;
      cs_rise = cyc;
      repeat (settle) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cs = 1'b1;
      repeat (3) @(negedge clk);
      check_cnt++; if (pix_we !== 1'b0) $display("FAIL reset_we got %b want 0", pix_we); else pass_cnt++;
      check_cnt++; if (pix_addr !== 6'd0) $display("FAIL reset_addr got %0d want 0", pix_addr); else pass_cnt++;
      check_cnt++; if (pix_rgb !== 24'd0) $display("FAIL reset_rgb got %h want 000000", pix_rgb); else pass_cnt++;
      check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
      check_cnt++; if (frame_done !== 1'b0) $display("FAIL reset_done got %b want 0", frame_done); else pass_cnt++;
      check_cnt++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else pass_cnt++;
      rst = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_single();
      clear_mon();
      cs_low();
      send_bits(32'h05FF8000, 32);
      cs_high(20);
      check_cnt++; if (we_cyc_q.size() != 1) $display("FAIL single_count got %0d want 1", we_cyc_q.size()); else pass_cnt++;
      if (we_cyc_q.size() >= 1) begin
         check_cnt++; if (we_addr_q[0] !== 6'd5) $display("FAIL single_addr got %0d want 5", we_addr_q[0]); else pass_cnt++;
         check_cnt++; if (we_rgb_q[0] !== 24'hFF8000) $display("FAIL single_rgb got %h want ff8000", we_rgb_q[0]); else pass_cnt++;
         check_cnt++; if (we_cyc_q[0] - last_rise != 3) $display("FAIL single_latency got %0d want 3", we_cyc_q[0] - last_rise); else pass_cnt++;
      end
      check_cnt++; if (done_q.size() != 1) $display("FAIL single_done_count got %0d want 1", done_q.size()); else pass_cnt++;
      if (done_q.size() >= 1) begin
         check_cnt++; if (done_q[0] - cs_rise != 3) $display("FAIL single_done_latency got %0d want 3", done_q[0] - cs_rise); else pass_cnt++;
      end
      check_cnt++; if (err_cnt != 0) $display("FAIL single_err got %0d want 0", err_cnt); else pass_cnt++;
      check_cnt++; if (pix_we !== 1'b0 || pix_addr !== 6'd5) $display("FAIL single_hold got we=%b addr=%0d want we=0 addr=5", pix_we, pix_addr); else pass_cnt++;
   endtask

   task automatic test_burst();
      logic [5:0]  exp_a[3];
      logic [23:0] exp_r[3];
      exp_a[0] = 6'd62; exp_r[0] = 24'h112233;
      exp_a[1] = 6'd63; exp_r[1] = 24'h445566;
      exp_a[2] = 6'd0;  exp_r[2] = 24'h778899;
      clear_mon();
      cs_low();
      send_bits(32'h7E112233, 32);
      send_bits(32'h00445566, 24);
      send_bits(32'h00778899, 24);
      cs_high(20);
      check_cnt++; if (we_cyc_q.size() != 3) $display("FAIL burst_count got %0d want 3", we_cyc_q.size()); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         if (we_cyc_q.size() > i) begin
            check_cnt++;
            if (we_addr_q[i] !== exp_a[i] || we_rgb_q[i] !== exp_r[i])
               $display("FAIL burst_px%0d got %0d/%h want %0d/%h", i, we_addr_q[i], we_rgb_q[i], exp_a[i], exp_r[i]);
            else pass_cnt++;
         end
      end
      check_cnt++; if (done_q.size() != 1) $display("FAIL burst_done got %0d want 1", done_q.size()); else pass_cnt++;
      check_cnt++; if (err_cnt != 0) $display("FAIL burst_err got %0d want 0", err_cnt); else pass_cnt++;
   endtask

   task automatic test_fill();
      int bad;
      clear_mon();
      cs_low();
      send_bits(32'h800000FF, 32);
      repeat (10) @(negedge clk);
      cs = 1'b1;
      repeat (100) @(negedge clk);
      check_cnt++; if (we_cyc_q.size() != 64) $display("FAIL fill_count got %0d want 64", we_cyc_q.size()); else pass_cnt++;
      if (we_cyc_q.size() == 64) begin
         bad = 0;
         for (int i = 0; i < 64; i++)
            if (we_addr_q[i] !== 6'(i) || we_rgb_q[i] !== 24'h0000FF || we_cyc_q[i] != we_cyc_q[0] + i) bad++;
         check_cnt++; if (bad != 0) $display("FAIL fill_sequence got %0d bad strobes want 0", bad); else pass_cnt++;
         check_cnt++; if (done_q.size() != 1 || done_q[0] != we_cyc_q[63] + 1)
            $display("FAIL fill_done got %0d pulses want 1 at cycle %0d", done_q.size(), we_cyc_q[63] + 1);
         else pass_cnt++;
      end
      check_cnt++; if (busy_cnt != 64) $display("FAIL fill_busy got %0d want 64", busy_cnt); else pass_cnt++;
      check_cnt++; if (err_cnt != 0) $display("FAIL fill_err got %0d want 0", err_cnt); else pass_cnt++;
   endtask

   task automatic test_err_cmd();
      clear_mon();
      cs_low();
      send_bits(32'hC5123456, 32);
      cs_high(20);
      check_cnt++; if (err_cnt != 1) $display("FAIL errcmd_err got %0d want 1", err_cnt); else pass_cnt++;
      check_cnt++; if (we_cyc_q.size() != 0) $display("FAIL errcmd_we got %0d want 0", we_cyc_q.size()); else pass_cnt++;
      check_cnt++; if (done_q.size() != 0) $display("FAIL errcmd_done got %0d want 0", done_q.size()); else pass_cnt++;
   endtask

   task automatic test_err_partial();
      clear_mon();
      cs_low();
      send_bits(32'h0000A5A5, 17);
      cs_high(20);
      check_cnt++; if (err_cnt != 1) $display("FAIL partial_err got %0d want 1", err_cnt); else pass_cnt++;
      check_cnt++; if (we_cyc_q.size() != 0) $display("FAIL partial_we got %0d want 0", we_cyc_q.size()); else pass_cnt++;
      check_cnt++; if (done_q.size() != 0 || both_cnt != 0) $display("FAIL partial_done got %0d/%0d want 0/0", done_q.size(), both_cnt); else pass_cnt++;
   endtask

   task automatic test_reset_mid_fill();
      int n;
      clear_mon();
      cs_low();
      send_bits(32'h80123456, 32);
      n = 0;
      while (we_cyc_q.size() < 20 && n < 500) begin
         @(negedge clk); #1;
         n++;
      end
      check_cnt++; if (n >= 500) $display("FAIL rstfill_timeout got %0d strobes want 20", we_cyc_q.size()); else pass_cnt++;
      rst = 1'b1;
      @(negedge clk);
      check_cnt++; if (pix_we !== 1'b0 || busy !== 1'b0) $display("FAIL rstfill_outputs got we=%b busy=%b want 0/0", pix_we, busy); else pass_cnt++;
      rst = 1'b0;
      cs = 1'b1;
      repeat (100) @(negedge clk);
      check_cnt++; if (we_cyc_q.size() != 20) $display("FAIL rstfill_count got %0d want 20", we_cyc_q.size()); else pass_cnt++;
      check_cnt++; if (err_cnt != 0 || done_q.size() != 0) $display("FAIL rstfill_flags got err=%0d done=%0d want 0/0", err_cnt, done_q.size()); else pass_cnt++;
      clear_mon();
      cs_low();
      send_bits(32'h2A0A0B0C, 32);
      cs_high(20);
      check_cnt++;
      if (we_cyc_q.size() != 1 || we_addr_q[0] !== 6'd42 || we_rgb_q[0] !== 24'h0A0B0C || done_q.size() != 1)
         $display("FAIL rstfill_after got %0d strobes want 1 at 42/0a0b0c with one frame_done", we_cyc_q.size());
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      clear_mon();
      cs_low();
      send_bits(32'h01AABBCC, 32);
      cs_high(4);
      cs_low();
      send_bits(32'h3F010203, 32);
      cs_high(20);
      check_cnt++; if (we_cyc_q.size() != 2) $display("FAIL b2b_count got %0d want 2", we_cyc_q.size()); else pass_cnt++;
      if (we_cyc_q.size() == 2) begin
         check_cnt++; if (we_addr_q[0] !== 6'd1 || we_rgb_q[0] !== 24'hAABBCC)
            $display("FAIL b2b_first got %0d/%h want 1/aabbcc", we_addr_q[0], we_rgb_q[0]); else pass_cnt++;
         check_cnt++; if (we_addr_q[1] !== 6'd63 || we_rgb_q[1] !== 24'h010203)
            $display("FAIL b2b_second got %0d/%h want 63/010203", we_addr_q[1], we_rgb_q[1]); else pass_cnt++;
      end
      check_cnt++; if (done_q.size() != 2) $display("FAIL b2b_done got %0d want 2", done_q.size()); else pass_cnt++;
      check_cnt++; if (err_cnt != 0) $display("FAIL b2b_err got %0d want 0", err_cnt); else pass_cnt++;
   endtask

   initial begin
      err_cnt = 0; busy_cnt = 0; both_cnt = 0;
      last_rise = 0; cs_rise = 0;
      @(negedge clk);
      test_reset();
      test_single();
      test_burst();
      test_fill();
      test_err_cmd();
      test_err_partial();
      test_reset_mid_fill();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
